fp_convert_sequencer: RTL and testbench
=======================================

Name: fp_convert_sequencer

Overview:
Multi-cycle controller that converts a 12-bit two's-complement sample into the team's 8-bit floating-point format (sign, 3-bit exponent, 4-bit significand). It takes absolute value, normalizes by one left shift per cycle, then performs a round-half-up step with significand overflow and saturation handling. It uses a valid/ready handshake on both sides and sits between the input-sample register and the display/encode stage.

Parameters:
IN_W, 12, input sample width (two's complement)
EXP_W, 3, exponent width
SIG_W, 4, significand width
- Constraint: IN_W-1 == (2**EXP_W - 1) + SIG_W. Only the defaults are verified.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  D holds a sample to convert
in_ready  output  1  block can accept a sample; high only in IDLE
D  input  IN_W  two's-complement sample, captured on in_valid&&in_ready
out_valid  output  1  S/E/F hold a finished result
out_ready  input  1  downstream consumes the result on out_valid&&out_ready
S  output  1  sign bit
E  output  EXP_W  exponent
F  output  SIG_W  significand

Behaviour:
- Reset (asynchronous, any state): state=IDLE, out_valid=0, S=0, E=0, F=0, internal regs cleared. in_ready=1 after reset deasserts.
- States: IDLE, ABS, NORM, ROUND, DONE.
- IDLE: in_ready=1. On in_valid: capture D, go to ABS. Otherwise stay.
- ABS (1 cycle):
  - sgn=D[11].
  - mag = sgn ? -D : D, computed in 12 bits.
  - D=12'h800 (-2048) sets sat_flag. The result for it is forced to S=1, E=7, F=15.
  - m[10:0]=mag[10:0], e=7. Go to NORM.
- NORM: each cycle:
  - If m[10]==0 and e!=0: m<=m<<1, e<=e-1, stay.
  - Else go to ROUND.
  - At most 7 shifts.
- ROUND (1 cycle):
  - sig=m[10:7]. fifth = (e!=0) ? m[6] : 0.
  - sum = sig + fifth, 5-bit result.
  - If fifth && sig==4'hF && e==7: E=7, F=4'hF (saturate).
  - Else if sum[4]: F=sum[4:1], E=e+1.
  - Else: F=sum[3:0], E=e.
  - S=sgn. sat_flag overrides to S=1, E=7, F=15.
  - Register S/E/F and go to DONE.
- DONE:
  - out_valid=1. S/E/F stay stable while out_valid=1 && out_ready=0.
  - On out_ready: out_valid<=0 on the next edge, go to IDLE.
  - in_ready stays 0 until IDLE; no accept in the same cycle as the output handshake.
- Latency from the accept edge to out_valid high = 3 + number of shifts. Range is 3..10 cycles.
- Zero input: 7 shifts, then E=0, F=0, S=0.
- in_valid outside IDLE is ignored and D is not sampled.
- out_ready outside DONE is ignored.
- Reset asserted mid-NORM or in DONE aborts immediately: out_valid=0, no result delivered.

Test Plan:
- D=12'd0 -> S=0, E=0, F=0; out_valid 10 cycles after accept.
- D=12'd46 -> 5 shifts; sig=1011, fifth=1 -> S=0, E=2, F=4'b1100; out_valid after 8 cycles.
- D=12'd125 and D=-125 (12'hF83) -> sig 1111 rounds and overflows -> E=4, F=4'b1000; S=0 and S=1 respectively; latency 7.
- D=12'h7FF -> saturate to S=0, E=7, F=15. D=12'h800 -> S=1, E=7, F=15. Both with latency 3.
- Hold out_ready=0 for 5 cycles in DONE -> out_valid and S/E/F stable, in_ready=0, a new in_valid is ignored. Then out_ready=1 -> back to IDLE; the next sample converts correctly.
- Assert rst during NORM of D=12'd1 -> out_valid=0 and S/E/F=0 immediately. After release, in_ready=1 and D=12'd1 gives E=0, F=1.

Source files
------------

// File: rtl/fp_convert_sequencer.sv
// -----------------------------------------------------------------------------
// fp_convert_sequencer
//
// Converts a two's-complement sample into the compact 8-bit floating-point
// format {S, E[2:0], F[3:0]}. The conversion is sequential: the block takes
// the absolute value, normalises with one left shift per clock, and then
// applies round-half-up with significand-overflow and saturation handling.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset (aborts any conversion)
//   in_valid   D holds a sample to convert
//   in_ready   block can accept a sample (high only while idle)
//   D          two's-complement sample, captured on in_valid && in_ready
//   out_valid  S/E/F hold a finished result
//   out_ready  downstream consumes the result on out_valid && out_ready
//   S          sign bit
//   E          exponent
//   F          significand
//
// Latency from the accept edge to out_valid is 3 + number of shifts (3..10).
// -----------------------------------------------------------------------------
module fp_convert_sequencer #(
    parameter int IN_W  = 12,
    parameter int EXP_W = 3,
    parameter int SIG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  D,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             S,
    output logic [EXP_W-1:0] E,
    output logic [SIG_W-1:0] F
);

    // Magnitude width: every representable magnitude except the most
    // negative input fits in IN_W-1 bits.
    localparam int M_W = IN_W - 1;

    localparam logic [EXP_W-1:0]       E_MAX    = '1;
    localparam logic [SIG_W-1:0]       F_MAX    = '1;
    localparam logic signed [IN_W-1:0] MOST_NEG = {1'b1, {(IN_W-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        ABS,
        NORM,
        ROUND,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic signed [IN_W-1:0]  d_q, d_d;
    logic                    sgn_q, sgn_d;
    logic                    sat_q, sat_d;
    logic [M_W-1:0]          m_q, m_d;
    logic [EXP_W-1:0]        e_q, e_d;
    logic                    s_q, s_d;
    logic [EXP_W-1:0]        eo_q, eo_d;
    logic [SIG_W-1:0]        f_q, f_d;
    logic                    out_valid_q, out_valid_d;
    logic [M_W-1:0]          mag;

    // Absolute value in IN_W bits, truncated to the magnitude width. The
    // most negative input wraps here; it is handled separately via sat_q.
    function automatic logic [M_W-1:0] abs_val(input logic signed [IN_W-1:0] x);
        abs_val = M_W'(x[IN_W-1] ? -x : x);
    endfunction

    // Round-half-up of the leading SIG_W bits using the next bit as guard.
    // With a zero exponent the value is already exact, so no guard is used.
    // A carry out of the significand renormalises (F = 1000, E + 1) unless
    // the exponent is already at its maximum, where the result saturates.
    function automatic logic [EXP_W+SIG_W-1:0] round_sat(
        input logic [SIG_W-1:0] sig,
        input logic             guard,
        input logic [EXP_W-1:0] e
    );
        logic             fifth;
        logic [SIG_W:0]   sum;
        logic [EXP_W-1:0] e_inc;
        fifth = (e != '0) ? guard : 1'b0;
        sum   = {1'b0, sig} + {{SIG_W{1'b0}}, fifth};
        e_inc = e + EXP_W'(1);
        if (fifth && (sig == F_MAX) && (e == E_MAX)) begin
            round_sat = {E_MAX, F_MAX};
        end else if (sum[SIG_W]) begin
            round_sat = {e_inc, sum[SIG_W:1]};
        end else begin
            round_sat = {e, sum[SIG_W-1:0]};
        end
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            d_q         <= '0;
            sgn_q       <= 1'b0;
            sat_q       <= 1'b0;
            m_q         <= '0;
            e_q         <= '0;
            s_q         <= 1'b0;
            eo_q        <= '0;
            f_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            d_q         <= d_d;
            sgn_q       <= sgn_d;
            sat_q       <= sat_d;
            m_q         <= m_d;
            e_q         <= e_d;
            s_q         <= s_d;
            eo_q        <= eo_d;
            f_q         <= f_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        d_d         = d_q;
        sgn_d       = sgn_q;
        sat_d       = sat_q;
        m_d         = m_q;
        e_d         = e_q;
        s_d         = s_q;
        eo_d        = eo_q;
        f_d         = f_q;
        out_valid_d = out_valid_q;
        mag         = abs_val(d_q);

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    d_d     = D;
                    state_d = ABS;
                end
            end

            ABS: begin
                sgn_d   = d_q[IN_W-1];
                sat_d   = (d_q == MOST_NEG);
                m_d     = mag;
                e_d     = E_MAX;
                state_d = NORM;
            end

            NORM: begin
                // The most negative input has a forced result, so it skips
                // normalisation entirely to keep its latency at 3.
                if (!sat_q && !m_q[M_W-1] && (e_q != '0)) begin
                    m_d = m_q << 1;
                    e_d = e_q - EXP_W'(1);
                end else begin
                    state_d = ROUND;
                end
            end

            ROUND: begin
                {eo_d, f_d} = round_sat(m_q[M_W-1 -: SIG_W], m_q[M_W-1-SIG_W], e_q);
                s_d         = sgn_q;
                if (sat_q) begin
                    s_d  = 1'b1;
                    eo_d = E_MAX;
                    f_d  = F_MAX;
                end
                out_valid_d = 1'b1;
                state_d     = DONE;
            end

            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign S         = s_q;
    assign E         = eo_q;
    assign F         = f_q;

endmodule

// File: tb/tb_fp_convert_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fp_convert_sequencer
//
// Self-checking bench for fp_convert_sequencer: directed corner samples,
// output back-pressure, reset aborts, and randomized samples checked against
// an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_fp_convert_sequencer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] D;
    logic        out_valid;
    logic        out_ready;
    logic        S;
    logic [2:0]  E;
    logic [3:0]  F;

    int n_vec = 0;
    int n_err = 0;

    fp_convert_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .D         (D),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .E         (E),
        .F         (F)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: value = F * 2^(E-?) style format. The exponent is the
    // position of the leading one minus 3 (floored at 0), the significand is
    // the magnitude shifted right by that exponent, and the bit just below
    // it rounds half-up. Latency is 3 + shifts, shifts = 7 - exponent.
    function automatic void model(input logic [11:0] d, output logic s,
                                  output logic [2:0] e, output logic [3:0] f,
                                  output int lat);
        int v, mag, p, ex, sig, fifth, r;
        v = int'($signed(d));
        if (v == -2048) begin
            s = 1'b1; e = 3'd7; f = 4'd15; lat = 3;
            return;
        end
        s   = (v < 0);
        mag = (v < 0) ? -v : v;
        p   = -1;
        for (int b = 0; b < 11; b++) begin
            if (((mag >> b) & 1) == 1) p = b;
        end
        ex    = (p > 3) ? p - 3 : 0;
        sig   = mag >> ex;
        fifth = (ex > 0) ? ((mag >> (ex - 1)) & 1) : 0;
        r     = sig + fifth;
        lat   = 10 - ex;
        if (r == 16) begin
            if (ex == 7) begin
                e = 3'd7; f = 4'd15;
            end else begin
                e = 3'(ex + 1); f = 4'd8;
            end
        end else begin
            e = 3'(ex); f = 4'(r);
        end
    endfunction

    // Apply one sample, check latency and result, hold the result for
    // 'hold' cycles of back-pressure, then consume it.
    task automatic convert(input logic [11:0] d, input int hold);
        logic xs;
        logic [2:0] xe;
        logic [3:0] xf;
        int xlat, lat;
        model(d, xs, xe, xf, xlat);
        @(negedge clk);
        D = d;
        in_valid = 1'b1;
        out_ready = 1'($urandom_range(0, 1));
        chk("in_ready_idle", int'(in_ready), 1);
        @(posedge clk);
        #1;
        lat = 0;
        while (!out_valid && lat < 20) begin
            in_valid = 1'($urandom_range(0, 1));
            D = 12'($urandom);
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", lat, xlat);
        chk("out_valid", int'(out_valid), 1);
        chk("S", int'(S), int'(xs));
        chk("E", int'(E), int'(xe));
        chk("F", int'(F), int'(xf));
        chk("in_ready_busy", int'(in_ready), 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            D = 12'($urandom);
            out_ready = 1'b0;
            @(posedge clk);
            #1;
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_SEF", int'({S, E, F}), int'({xs, xe, xf}));
            chk("hold_in_ready", int'(in_ready), 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("consumed_valid", int'(out_valid), 0);
        chk("back_idle", int'(in_ready), 1);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int seen;
        logic [11:0] rd;
        int mag;

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        D = '0;
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_SEF", int'({S, E, F}), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", int'(in_ready), 1);

        // Directed corners
        convert(12'd0, 0);
        convert(12'd46, 0);
        convert(12'd125, 1);
        convert(12'hF83, 0);
        convert(12'h7FF, 0);
        convert(12'h800, 2);
        convert(12'd1, 0);
        convert(12'd8, 0);
        convert(12'd15, 0);
        convert(12'd16, 0);
        convert(12'hFFF, 0);
        convert(12'd1023, 0);
        convert(12'd1024, 0);

        // Back-pressure in DONE, then a fresh sample
        convert(12'd46, 5);
        convert(12'hF83, 0);

        // Reset during NORM aborts; S/E/F previously nonzero
        convert(12'h800, 0);
        @(negedge clk);
        D = 12'd1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_norm_valid", int'(out_valid), 0);
        chk("abort_norm_SEF", int'({S, E, F}), 0);
        chk("abort_norm_in_ready", int'(in_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1;
        end
        chk("abort_no_result", seen, 0);
        convert(12'd1, 0);

        // Reset while holding a result in DONE
        @(negedge clk);
        D = 12'h7FF;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_abort_done_valid", int'(out_valid), 1);
        rst = 1'b1;
        #1;
        chk("abort_done_valid", int'(out_valid), 0);
        chk("abort_done_SEF", int'({S, E, F}), 0);
        @(negedge clk);
        rst = 1'b0;
        convert(12'hF83, 0);

        // Randomized samples, biased toward small magnitudes
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                mag = $urandom_range(0, 140);
                rd = ($urandom_range(0, 1) == 1) ? 12'(-mag) : 12'(mag);
            end else begin
                rd = 12'($urandom);
            end
            convert(rd, $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
